// File: rtl/seven_seg_scan_driver_if.sv
// seven_seg_scan_driver_if
//   Bundles the digit data coming from the time-keeping logic and the
//   scanned display pins driven toward the board.
//   master : time-keeping side; drives digit data, observes display pins
//   slave  : scan driver; consumes digit data, drives display pins
//   Signals:
//     digits_in [4*DIGITS]  digit i value at [4i+3:4i]
//     dp_in     [DIGITS]    1 = decimal point of digit i lit
//     blank_in  [DIGITS]    1 = digit i dark
//     blink_in  [DIGITS]    1 = digit i blinks
//     segments  [7]         active-low, bit 6..0 = a..g
//     dp                    active-low decimal point
//     anodes    [DIGITS]    active-low digit enables
interface seven_seg_scan_driver_if #(
   parameter int unsigned DIGITS = 4
);
   logic [4*DIGITS-1:0] digits_in;
   logic [DIGITS-1:0]   dp_in;
   logic [DIGITS-1:0]   blank_in;
   logic [DIGITS-1:0]   blink_in;
   logic [6:0]          segments;
   logic                dp;
   logic [DIGITS-1:0]   anodes;

   modport master (
      output digits_in, dp_in, blank_in, blink_in,
      input  segments, dp, anodes
   );

   modport slave (
      input  digits_in, dp_in, blank_in, blink_in,
      output segments, dp, anodes
   );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//   Time-multiplexed driver for a DIGITS-wide common-anode seven-segment
//   display. Digit data is captured into shadow registers once per frame
//   so a frame never shows a mix of old and new values. Each digit slot
//   starts with GUARD cycles of all anodes off. Supports per-digit decimal
//   point, blanking and blinking. All outputs are registered.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  synchronous active-low reset
//     bus    seven_seg_scan_driver_if.slave (digit data in, display pins out)
//   Build option:
//     SEVEN_SEG_HEX_EN  defined: values 10-15 show hex glyphs A b C d E F;
//                       undefined: values 10-15 show a dash (segment g).
module seven_seg_scan_driver #(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned GUARD       = 16,
   parameter int unsigned BLINK_DIV   = 250
) (
   input  logic                    clk,
   input  logic                    rst_n,
   seven_seg_scan_driver_if.slave  bus
);

   localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IW = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;
   localparam int unsigned FW = (BLINK_DIV > 1)   ? $clog2(BLINK_DIV)   : 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
   localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_DIV - 1);

   // scan state
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic [FW-1:0] frm;
   logic          phase;

   // per-frame shadows of the input data
   logic [DIGITS-1:0][3:0] val_s;
   logic [DIGITS-1:0]      dp_s;
   logic [DIGITS-1:0]      blank_s;
   logic [DIGITS-1:0]      blink_s;

   // registered outputs
   logic [6:0]        seg_q;
   logic              dp_q;
   logic [DIGITS-1:0] an_q;

   // next-output combinational values
   logic              cnt_wrap;
   logic              frame_end;
   logic              in_guard;
   logic              dark;
   logic              lit;
   logic [3:0]        cur_val;
   logic [6:0]        seg_n;
   logic              dp_n;
   logic [DIGITS-1:0] an_n;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] g;
      g = 7'b1111110;
      case (v)
         4'h0: g = 7'b0000001;
         4'h1: g = 7'b1001111;
         4'h2: g = 7'b0010010;
         4'h3: g = 7'b0000110;
         4'h4: g = 7'b1001100;
         4'h5: g = 7'b0100100;
         4'h6: g = 7'b0100000;
         4'h7: g = 7'b0001111;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0000100;
`ifdef SEVEN_SEG_HEX_EN
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b1100000;
         4'hC: g = 7'b0110001;
         4'hD: g = 7'b1000010;
         4'hE: g = 7'b0110000;
         4'hF: g = 7'b0111000;
`else
         4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: g = 7'b1111110;
`endif
         default: g = 7'b1111110;
      endcase
      return g;
   endfunction

   // GUARD == 0 would make the compare trivially false; keep it structural.
   generate
      if (GUARD == 0) begin : g_no_guard
         assign in_guard = 1'b0;
      end else begin : g_guard
         assign in_guard = (cnt < CW'(GUARD));
      end
   endgenerate

   always_comb begin
      cnt_wrap  = (cnt == CNT_LAST);
      frame_end = cnt_wrap && (idx == IDX_LAST);
      cur_val   = val_s[idx];
      dark      = blank_s[idx] || (blink_s[idx] && phase);
      lit       = !in_guard && !dark;
      an_n      = '1;
      seg_n     = '1;
      dp_n      = 1'b1;
      if (lit) begin
         an_n[idx] = 1'b0;
         seg_n     = decode(cur_val);
         dp_n      = ~dp_s[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt     <= '0;
         idx     <= '0;
         frm     <= '0;
         phase   <= 1'b0;
         val_s   <= '0;
         dp_s    <= '0;
         blink_s <= '0;
         blank_s <= '1;
         seg_q   <= '1;
         dp_q    <= 1'b1;
         an_q    <= '1;
      end else begin
         seg_q <= seg_n;
         dp_q  <= dp_n;
         an_q  <= an_n;

         cnt <= cnt_wrap ? '0 : cnt + 1'b1;
         if (cnt_wrap) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end

         // shadows and blink phase change on the same edge so the next
         // slot sees both updates together
         if (frame_end) begin
            val_s   <= bus.digits_in;
            dp_s    <= bus.dp_in;
            blank_s <= bus.blank_in;
            blink_s <= bus.blink_in;
            if (frm == FRM_LAST) begin
               frm   <= '0;
               phase <= ~phase;
            end else begin
               frm <= frm + 1'b1;
            end
         end
      end
   end

   assign bus.segments = seg_q;
   assign bus.dp       = dp_q;
   assign bus.anodes   = an_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver
//   Scoreboard bench: before every clock edge the expected registered
//   outputs are derived from the absolute cycle position since reset and
//   the data the bench itself handed over at each frame end, pushed to a
//   queue, and compared after the edge.
module tb_seven_seg_scan_driver;

   localparam int unsigned DIGITS      = 4;
   localparam int unsigned REFRESH_DIV = 8;
   localparam int unsigned GUARD       = 2;
   localparam int unsigned BLINK_DIV   = 2;
   localparam int unsigned FRAME       = DIGITS * REFRESH_DIV;
   localparam logic [11:0] RST_OUT     = 12'hFFF;

   logic clk;
   logic rst_n;

   seven_seg_scan_driver_if #(.DIGITS(DIGITS)) bus ();

   seven_seg_scan_driver #(
      .DIGITS      (DIGITS),
      .REFRESH_DIV (REFRESH_DIV),
      .GUARD       (GUARD),
      .BLINK_DIV   (BLINK_DIV)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_pass;

   // model state: cycles since reset plus what was handed over at frame ends
   int         s;
   logic [3:0] m_val [DIGITS];
   logic [DIGITS-1:0] m_dp, m_blank, m_blink;
   logic [6:0] glyph_tab [16];
   logic [11:0] exp_q [$];

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s @s=%0d: an/seg/dp got %b_%b_%b expected %b_%b_%b",
                    tag, s, obs[11:8], obs[7:1], obs[0], exp[11:8], exp[7:1], exp[0]);
   endtask

   task automatic model_reset();
      for (int i = 0; i < DIGITS; i++) m_val[i] = 4'h0;
      m_dp    = '0;
      m_blink = '0;
      m_blank = '1;
      s       = 0;
   endtask

   function automatic logic [11:0] expect_out(input int st);
      int         c, d, f;
      logic       ph;
      logic [3:0] an;
      c  = st % REFRESH_DIV;
      d  = (st / REFRESH_DIV) % DIGITS;
      f  = st / FRAME;
      ph = ((f / BLINK_DIV) % 2) == 1;
      if (c < GUARD || m_blank[d] || (m_blink[d] && ph)) return RST_OUT;
      an    = 4'b1111;
      an[d] = 1'b0;
      return {an, glyph_tab[m_val[d]], ~m_dp[d]};
   endfunction

   task automatic step(input string tag);
      logic              cap;
      logic [4*DIGITS-1:0] dv;
      logic [3:0]        p_val [DIGITS];
      logic [DIGITS-1:0] p_dp, p_blank, p_blink;
      if (!rst_n) exp_q.push_back(RST_OUT);
      else        exp_q.push_back(expect_out(s));
      cap = rst_n && ((s % FRAME) == FRAME - 1);
      dv  = bus.digits_in;
      for (int i = 0; i < DIGITS; i++) p_val[i] = dv[4*i +: 4];
      p_dp    = bus.dp_in;
      p_blank = bus.blank_in;
      p_blink = bus.blink_in;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         check(tag, {bus.anodes, bus.segments, bus.dp}, exp_q.pop_front());
      end
      if (!rst_n) begin
         model_reset();
      end else begin
         s++;
         if (cap) begin
            for (int i = 0; i < DIGITS; i++) m_val[i] = p_val[i];
            m_dp    = p_dp;
            m_blank = p_blank;
            m_blink = p_blink;
         end
      end
   endtask

   task automatic run_until(input int target, input string tag);
      while (s < target) step(tag);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      glyph_tab[0]  = 7'b0000001;  glyph_tab[1]  = 7'b1001111;
      glyph_tab[2]  = 7'b0010010;  glyph_tab[3]  = 7'b0000110;
      glyph_tab[4]  = 7'b1001100;  glyph_tab[5]  = 7'b0100100;
      glyph_tab[6]  = 7'b0100000;  glyph_tab[7]  = 7'b0001111;
      glyph_tab[8]  = 7'b0000000;  glyph_tab[9]  = 7'b0000100;
`ifdef SEVEN_SEG_HEX_EN
      glyph_tab[10] = 7'b0001000;  glyph_tab[11] = 7'b1100000;
      glyph_tab[12] = 7'b0110001;  glyph_tab[13] = 7'b1000010;
      glyph_tab[14] = 7'b0110000;  glyph_tab[15] = 7'b0111000;
`else
      for (int i = 10; i < 16; i++) glyph_tab[i] = 7'b1111110;
`endif
      model_reset();

      rst_n         = 1'b0;
      bus.digits_in = 16'h1234;
      bus.dp_in     = '0;
      bus.blank_in  = '0;
      bus.blink_in  = '0;
      for (int i = 0; i < 3; i++) step("rst");

      // first frame after reset stays dark
      rst_n     = 1'b1;
      bus.dp_in = 4'b0010;
      run_until(FRAME, "frame0");

      // frame 1 shows 4,3,2,1 with dp on digit 1
      run_until(2*FRAME, "scan");

      // change mid-frame (slot 2, cycle 3): frame 2 still 1234, frame 3 5678
      run_until(2*FRAME + 2*REFRESH_DIV + 3, "tear");
      bus.digits_in = 16'h5678;
      run_until(4*FRAME, "tear");

      // digit 3 blanked, digit 0 blinking
      bus.blink_in = 4'b0001;
      bus.blank_in = 4'b1000;
      run_until(13*FRAME, "blink");

      // hex values 10..15 region
      bus.digits_in = 16'h00FA;
      bus.blink_in  = '0;
      bus.blank_in  = '0;
      run_until(15*FRAME, "hex");

      // reset in slot 2, cycle 5
      run_until(15*FRAME + 2*REFRESH_DIV + 5, "pre_midrst");
      rst_n = 1'b0;
      step("midrst");
      rst_n = 1'b1;
      run_until(FRAME + REFRESH_DIV, "post_midrst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
